load_use_interlock: RTL and testbench

//  Interlock between decode and execute for the LC-3b 5-stage pipeline.

---
 rtl/load_use_interlock.sv | 120 ++++++++++++
 tb/tb_load_use_interlock.sv | 130 +++++++++++++
 2 files changed

// File: rtl/load_use_interlock.sv
// Load-use interlock for the LC-3b pipeline: tracks in-flight loads per
// destination register and stalls decode until the load result is forwardable.
module load_use_interlock #(
  parameter int NUM_REGS = 8,
  parameter int REG_W    = 3,
  parameter int CNT_W    = 2,
  parameter int STALL_CW = 8,
  parameter int WD_LIMIT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_all,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_sr1,
  input  logic [REG_W-1:0]    id_sr2,
  input  logic                id_sr1_used,
  input  logic                id_sr2_used,
  input  logic                id_is_load,
  input  logic [REG_W-1:0]    id_dest,
  input  logic                mem_load_done,
  input  logic [REG_W-1:0]    mem_load_dest,
  input  logic                flush,
  output logic                hold_id,
  output logic                bubble_ex,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [STALL_CW-1:0] stall_count,
  output logic                watchdog_err
);

  localparam logic [CNT_W:0] CNT_MAX = (CNT_W+1)'(2);

  typedef enum logic {RUN, INTERLOCK} state_e;

  state_e                         state_q, state_d;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                           ex_load_v_q, ex_load_v_d;
  logic [REG_W-1:0]               ex_load_dest_q, ex_load_dest_d;
  logic [STALL_CW-1:0]            stall_count_q, stall_count_d;
  logic                           wd_q, wd_d;
  logic [NUM_REGS-1:0]            busy;
  logic                           hazard, issue;

  // A load finishing in MEM this cycle is forwardable next cycle, so it
  // no longer blocks the consumer if it was the last one in flight.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic           inc, dec_m, dec_f;
    logic [1:0]     dec;
    logic [CNT_W:0] sum, nxt;

    assign busy[r] = (cnt_q[r] != '0) &&
                     !(mem_load_done && mem_load_dest == REG_W'(r) &&
                       cnt_q[r] == CNT_W'(1));
    assign pending_mask[r] = (cnt_q[r] != '0);

    always_comb begin
      inc   = issue && (id_dest == REG_W'(r));
      dec_m = mem_load_done && (mem_load_dest == REG_W'(r));
      dec_f = flush && ex_load_v_q && (ex_load_dest_q == REG_W'(r));
      dec   = {1'b0, dec_m} + {1'b0, dec_f};
      sum   = {1'b0, cnt_q[r]} + (CNT_W+1)'(inc);
      if (sum <= (CNT_W+1)'(dec)) nxt = '0;
      else                        nxt = sum - (CNT_W+1)'(dec);
      if (nxt > CNT_MAX) nxt = CNT_MAX;
      cnt_d[r] = stall_all ? cnt_q[r] : nxt[CNT_W-1:0];
    end
  end

  always_comb begin
    hazard = id_valid && !flush &&
             ((id_sr1_used && busy[id_sr1]) || (id_sr2_used && busy[id_sr2]));
    issue  = id_valid && id_is_load && !hazard && !flush && !stall_all;
  end

  assign hold_id      = hazard;
  assign bubble_ex    = hazard;
  assign stall_count  = stall_count_q;
  assign watchdog_err = wd_q;

  always_comb begin
    state_d        = state_q;
    ex_load_v_d    = ex_load_v_q;
    ex_load_dest_d = ex_load_dest_q;
    stall_count_d  = stall_count_q;
    wd_d           = wd_q;
    if (!stall_all) begin
      ex_load_v_d = issue;
      if (issue) ex_load_dest_d = id_dest;
      case (state_q)
        RUN:       if (hazard)          state_d = INTERLOCK;
        INTERLOCK: if (!hazard || flush) state_d = RUN;
        default:                        state_d = RUN;
      endcase
      if (hazard) begin
        if (!(&stall_count_q)) stall_count_d = stall_count_q + 1'b1;
        if (stall_count_q == STALL_CW'(WD_LIMIT-1)) wd_d = 1'b1;
      end else begin
        stall_count_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      ex_load_v_q    <= 1'b0;
      ex_load_dest_q <= '0;
      stall_count_q  <= '0;
      wd_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      ex_load_v_q    <= ex_load_v_d;
      ex_load_dest_q <= ex_load_dest_d;
      stall_count_q  <= stall_count_d;
      wd_q           <= wd_d;
    end
  end

endmodule

// File: tb/tb_load_use_interlock.sv
// Directed bench for load_use_interlock: drives on the falling edge, checks
// just after, so registered state reflects the previous rising edge.
module tb_load_use_interlock;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       stall_all, id_valid, id_sr1_used, id_sr2_used, id_is_load;
  logic [2:0] id_sr1, id_sr2, id_dest, mem_load_dest;
  logic       mem_load_done, flush;
  logic       hold_id, bubble_ex, watchdog_err;
  logic [7:0] pending_mask, stall_count;
  int         n_tests = 0, n_fail = 0;

  load_use_interlock dut (
    .clk(clk), .rst_n(rst_n), .stall_all(stall_all), .id_valid(id_valid),
    .id_sr1(id_sr1), .id_sr2(id_sr2), .id_sr1_used(id_sr1_used),
    .id_sr2_used(id_sr2_used), .id_is_load(id_is_load), .id_dest(id_dest),
    .mem_load_done(mem_load_done), .mem_load_dest(mem_load_dest), .flush(flush),
    .hold_id(hold_id), .bubble_ex(bubble_ex), .pending_mask(pending_mask),
    .stall_count(stall_count), .watchdog_err(watchdog_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    stall_all = 0; id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_sr1_used = 0;
    id_sr2_used = 0; id_is_load = 0; id_dest = 0; mem_load_done = 0;
    mem_load_dest = 0; flush = 0;
  endtask

  task automatic ldr(input logic [2:0] d);
    idle(); id_valid = 1; id_is_load = 1; id_dest = d;
  endtask

  task automatic use1(input logic [2:0] s1, input logic [2:0] s2, input logic u2);
    idle(); id_valid = 1; id_sr1 = s1; id_sr1_used = 1; id_sr2 = s2; id_sr2_used = u2;
  endtask

  task automatic done(input logic [2:0] d);
    mem_load_done = 1; mem_load_dest = d;
  endtask

  // advance one full clock, landing on the next falling edge
  task automatic cyc();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic hz(input string tag, input logic exp);
    #1;
    chk({tag, ".hold"}, hold_id, exp);
    chk({tag, ".bubble"}, bubble_ex, exp);
  endtask

  initial begin
    idle();
    @(negedge clk); #1;
    chk("rst.hold", hold_id, 0); chk("rst.pend", pending_mask, 0);
    chk("rst.sc", stall_count, 0); chk("rst.wd", watchdog_err, 0);
    rst_n = 1; @(negedge clk);

    // 1: LDR R1; ADD R2,R1,R3 stalls exactly one cycle
    ldr(1); hz("t1.a", 0); cyc();
    use1(1, 3, 1); hz("t1.b", 1); chk("t1.b.pend", pending_mask, 8'h02); cyc();
    done(1); hz("t1.c", 0); chk("t1.c.sc", stall_count, 1);
    chk("t1.c.pend", pending_mask, 8'h02); cyc();
    idle(); #1; chk("t1.d.pend", pending_mask, 0); chk("t1.d.sc", stall_count, 0); cyc();

    // 2: same, with a 3-cycle global freeze while the load sits in MEM
    ldr(1); cyc();
    use1(1, 3, 1); hz("t2.b", 1); cyc();
    for (int i = 0; i < 3; i++) begin
      use1(1, 3, 1); stall_all = 1; hz("t2.frz", 1);
      chk("t2.frz.sc", stall_count, 1); chk("t2.frz.pend", pending_mask, 8'h02); cyc();
    end
    use1(1, 3, 1); done(1); hz("t2.rel", 0); cyc();
    idle(); #1; chk("t2.end.pend", pending_mask, 0); chk("t2.end.sc", stall_count, 0); cyc();

    // 3: unused sr2 matching a pending load never stalls
    ldr(4); hz("t3.a", 0); cyc();
    use1(6, 4, 0); hz("t3.b", 0); chk("t3.b.pend", pending_mask, 8'h10); cyc();
    idle(); done(4); hz("t3.c", 0); chk("t3.c.pend", pending_mask, 8'h10); cyc();
    idle(); #1; chk("t3.d.pend", pending_mask, 0); cyc();

    // 4: two loads to R1 back to back; consumer waits for both
    ldr(1); cyc();
    ldr(1); id_sr1 = 2; id_sr1_used = 1; hz("t4.b", 0); cyc();
    use1(1, 0, 0); done(1); hz("t4.c", 1); chk("t4.c.pend", pending_mask, 8'h02); cyc();
    use1(1, 0, 0); done(1); hz("t4.d", 0); chk("t4.d.pend", pending_mask, 8'h02);
    chk("t4.d.sc", stall_count, 1); cyc();
    idle(); #1; chk("t4.e.pend", pending_mask, 0); chk("t4.e.sc", stall_count, 0); cyc();

    // 5: flush kills the load in EX and the stalled consumer
    ldr(2); cyc();
    use1(2, 0, 0); hz("t5.pre", 1);
    flush = 1; hz("t5.fl", 0); cyc();
    idle(); #1; chk("t5.pend", pending_mask, 0); chk("t5.sc", stall_count, 0); cyc();

    // 6: watchdog after 64 consecutive interlock cycles
    ldr(3); cyc();
    for (int i = 0; i < 64; i++) begin
      use1(3, 0, 0); #1;
      if (i == 63) begin
        chk("t6.sc63", stall_count, 63); chk("t6.wd_pre", watchdog_err, 0);
      end
      cyc();
    end
    #1; chk("t6.wd", watchdog_err, 1); chk("t6.sc64", stall_count, 64);
    cyc(); cyc(); #1; chk("t6.wd_hold", watchdog_err, 1); chk("t6.hold", hold_id, 1);
    rst_n = 0; #1;
    chk("t6.rst.hold", hold_id, 0); chk("t6.rst.bub", bubble_ex, 0);
    chk("t6.rst.pend", pending_mask, 0); chk("t6.rst.sc", stall_count, 0);
    chk("t6.rst.wd", watchdog_err, 0);
    idle(); @(negedge clk); rst_n = 1; cyc();
    #1; chk("t6.post.wd", watchdog_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
